config_spi_rx: RTL and testbench

SPI-style serial configuration receiver: the fourth configuration port of the eFPGA configuration block, in parallel with the UART and bit-bang ports. It samples an external SPI mode-0 stream (sclk, mosi, cs_n) in the fabric clock domain, assembles MSB-first 32-bit words, and presents each word as a one-cycle write strobe plus data. These feed the configuration write-port priority mux ahead of the configuration FSM. Its `active` output drives the mux select and contributes to the FSM reset.

---
 rtl/config_spi_rx_if.sv | 34 +++
 rtl/config_spi_rx.sv | 188 ++++++++++++++++++
 tb/tb_config_spi_rx.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/config_spi_rx_if.sv
// rtl/config_spi_rx_if.sv - pin and word-output bundle for the SPI configuration receiver
//
// Signals:
//   sclk        external serial clock (asynchronous to CLK)
//   mosi        serial data, MSB first, sampled on sclk rising edge
//   cs_n        chip select, active low (asynchronous)
//   data        last completed 32-bit word
//   strobe      one-cycle pulse when data is updated
//   active      port busy, drives the configuration write-mux select
//   frame_err   one-cycle pulse when cs_n is released mid-word
//   word_count  words received in the current transaction (saturating)
//
// master: the side that drives the SPI pins (bench / pad ring)
// slave : the receiver itself
interface config_spi_rx_if;
    logic        sclk;
    logic        mosi;
    logic        cs_n;
    logic [31:0] data;
    logic        strobe;
    logic        active;
    logic        frame_err;
    logic [15:0] word_count;

    modport master (
        output sclk, mosi, cs_n,
        input  data, strobe, active, frame_err, word_count
    );

    modport slave (
        input  sclk, mosi, cs_n,
        output data, strobe, active, frame_err, word_count
    );
endinterface

// File: rtl/config_spi_rx.sv
// rtl/config_spi_rx.sv - SPI mode-0 configuration word receiver in the fabric clock domain
//
// Parameters:
//   SYNC_STAGES  synchroniser depth on sclk, mosi and cs_n (2..4)
//   ACTIVE_HOLD  CLK cycles active stays high after cs_n deasserts (1..255)
//
// Ports:
//   CLK     fabric/configuration clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     config_spi_rx_if.slave: sclk/mosi/cs_n in; data, strobe, active,
//           frame_err, word_count out
//
// Pipeline from a raw sclk rising edge to the strobe:
//   SYNC_STAGES cycles synchroniser -> 1 cycle registered edge detect ->
//   1 cycle data/strobe register.
module config_spi_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int ACTIVE_HOLD = 16
) (
    input  logic            CLK,
    input  logic            resetn,
    config_spi_rx_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // The hold counter counts down to zero and the FSM leaves HOLD one cycle
    // after reaching it, so loading ACTIVE_HOLD-1 makes active fall exactly
    // ACTIVE_HOLD+1 cycles after the synchronised cs_n rises.
    localparam logic [7:0] HOLD_LOAD = 8'(ACTIVE_HOLD - 1);

    // ------------------------------------------------------------------
    // Synchronisers. All three pins use the same depth so mosi stays
    // aligned with the sclk edge it belongs to.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] csn_sync_q;

    logic sclk_s;
    logic mosi_s;
    logic csn_s;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            csn_sync_q  <= '1;   // deselected while in reset
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0],  bus.cs_n};
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign csn_s  = csn_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Registered rising-edge detect. mosi is captured alongside so the
    // bit presented with edge_q is the one sampled on that sclk edge.
    // ------------------------------------------------------------------
    logic sclk_prev_q;
    logic edge_q;
    logic mosi_q;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            sclk_prev_q <= 1'b0;
            edge_q      <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_s;
            edge_q      <= sclk_s & ~sclk_prev_q;
            mosi_q      <= mosi_s;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM and datapath
    // ------------------------------------------------------------------
    state_t      state_q,    state_d;
    logic [31:0] shift_q,    shift_d;
    logic [31:0] data_q,     data_d;
    logic [4:0]  bit_cnt_q,  bit_cnt_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic        strobe_q,   strobe_d;
    logic        ferr_q,     ferr_d;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            data_q     <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            hold_cnt_q <= '0;
            strobe_q   <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            strobe_q   <= strobe_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        data_d     = data_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        hold_cnt_d = hold_cnt_q;
        strobe_d   = 1'b0;
        ferr_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!csn_s) begin
                    state_d    = ST_SHIFT;
                    shift_d    = '0;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                end
            end

            ST_SHIFT: begin
                // cs_n release wins over an sclk edge seen in the same cycle.
                if (csn_s) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                    // A partial word is simply abandoned: bit_cnt is cleared
                    // on the next entry to SHIFT, so its bits never surface.
                    if (bit_cnt_q != 5'd0) begin
                        ferr_d = 1'b1;
                    end
                end else if (edge_q) begin
                    shift_d   = {shift_q[30:0], mosi_q};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd31) begin
                        data_d   = {shift_q[30:0], mosi_q};
                        strobe_d = 1'b1;
                        if (word_cnt_q != 16'hFFFF) begin
                            word_cnt_d = word_cnt_q + 16'd1;
                        end
                    end
                end
            end

            ST_HOLD: begin
                // Reselect keeps the port active; the new transaction starts
                // its word count from zero.
                if (!csn_s) begin
                    state_d    = ST_SHIFT;
                    shift_d    = '0;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                end else if (hold_cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.data       = data_q;
    assign bus.strobe     = strobe_q;
    assign bus.active     = (state_q != ST_IDLE);
    assign bus.frame_err  = ferr_q;
    assign bus.word_count = word_cnt_q;

endmodule

// File: tb/tb_config_spi_rx.sv
// tb/tb_config_spi_rx.sv - self-checking bench for config_spi_rx
module tb_config_spi_rx;

    localparam int S = 2;
    localparam int H = 16;

    logic CLK = 1'b0;
    logic resetn;

    always #5 CLK = ~CLK;

    config_spi_rx_if bus ();

    config_spi_rx #(
        .SYNC_STAGES(S),
        .ACTIVE_HOLD(H)
    ) dut (
        .CLK    (CLK),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- cycle counter and output monitor ----------------
    int cyc = 0;
    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    logic [31:0] sq_data[$];
    int          sq_wc[$];
    int          sq_cyc[$];
    int          ferr_cnt     = 0;
    int          rises        = 0;
    int          falls        = 0;
    int          act_rise_cyc = 0;
    int          act_fall_cyc = 0;
    int          wide_cnt     = 0;
    logic        prev_strobe  = 1'b0;
    logic        prev_ferr    = 1'b0;
    logic        prev_active  = 1'b0;

    initial forever begin
        @(negedge CLK);
        if (resetn === 1'b1) begin
            if (bus.strobe) begin
                sq_data.push_back(bus.data);
                sq_wc.push_back(int'(bus.word_count));
                sq_cyc.push_back(cyc);
            end
            if (bus.frame_err) ferr_cnt++;
            if (bus.strobe && prev_strobe) wide_cnt++;
            if (bus.frame_err && prev_ferr) wide_cnt++;
            if (bus.active && !prev_active) begin
                rises++;
                act_rise_cyc = cyc;
            end
            if (!bus.active && prev_active) begin
                falls++;
                act_fall_cyc = cyc;
            end
        end
        prev_strobe = bus.strobe;
        prev_ferr   = bus.frame_err;
        prev_active = bus.active;
    end

    // ---------------- stimulus helpers ----------------
    int          last_edge;
    int          e32[3];
    int          c0, c1;
    int          rise0, fall0;
    logic [31:0] wbuf[3];
    logic [31:0] pword;
    logic [31:0] model_data = 32'h0;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    // sclk = CLK/8: 4 cycles low with mosi set up, 4 cycles high
    task automatic send_bit(input logic b);
        bus.mosi = b;
        tick(4);
        bus.sclk  = 1'b1;
        last_edge = cyc;
        tick(4);
        bus.sclk = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int nbits);
        for (int i = 31; i > 31 - nbits; i--) send_bit(w[i]);
    endtask

    task automatic clear_mon();
        sq_data.delete();
        sq_wc.delete();
        sq_cyc.delete();
        ferr_cnt = 0;
        rise0    = rises;
        fall0    = falls;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.active && k < 300) begin
            tick(1);
            k++;
        end
        check("idle_reached", bus.active, 0);
    endtask

    task automatic run_window(input int nfull, input int pbits);
        clear_mon();
        bus.cs_n = 1'b0;
        c0 = cyc;
        tick(4);
        for (int i = 0; i < nfull; i++) begin
            send_word(wbuf[i], 32);
            e32[i] = last_edge;
        end
        if (pbits > 0) send_word(pword, pbits);
        tick(4);
        bus.cs_n = 1'b1;
        c1 = cyc;
        wait_idle();
        tick(S + 4);
    endtask

    task automatic check_window(input logic [31:0] exp_data, input int exp_strobes,
                                input int exp_ferr, input int exp_wc, input int nfull);
        check("strobe_count", sq_data.size(), exp_strobes);
        for (int i = 0; i < nfull && i < sq_data.size(); i++) begin
            check("strobe_data", sq_data[i], wbuf[i]);
            check("strobe_wc", sq_wc[i], i + 1);
            check("strobe_latency", sq_cyc[i] - e32[i], S + 2);
        end
        check("frame_err_count", ferr_cnt, exp_ferr);
        check("data_after", bus.data, exp_data);
        check("word_count_after", bus.word_count, exp_wc);
        check("active_rise_count", rises - rise0, 1);
        check("active_rise_latency", act_rise_cyc - c0, S + 1);
        check("active_fall_count", falls - fall0, 1);
        check("active_fall_latency", act_fall_cyc - c1, S + H + 1);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int          nfull;
        int          pbits;
        logic [31:0] w0, w1, w2, pw;
        logic [31:0] exp_data;
        int          exp_strobes;
        int          exp_ferr;
        int          exp_wc;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{1, 0,  32'hF00DCAFE, 32'h0,        32'h0,        32'h0,        32'hF00DCAFE, 1, 0, 1};
        tbl[1] = '{3, 0,  32'h00000001, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 3, 0, 3};
        tbl[2] = '{0, 17, 32'h0,        32'h0,        32'h0,        32'hA5A5A5A5, 32'hFFFFFFFF, 0, 1, 0};
        tbl[3] = '{1, 0,  32'h0BADBEEF, 32'h0,        32'h0,        32'h0,        32'h0BADBEEF, 1, 0, 1};
        tbl[4] = '{2, 5,  32'h13579BDF, 32'h2468ACE0, 32'h0,        32'hFFFFFFFF, 32'h2468ACE0, 2, 1, 2};

        resetn   = 1'b0;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        bus.cs_n = 1'b1;
        tick(1);

        // reset values while inputs toggle
        for (int i = 0; i < 8; i++) begin
            bus.sclk = 1'($urandom_range(0, 1));
            bus.mosi = 1'($urandom_range(0, 1));
            bus.cs_n = 1'($urandom_range(0, 1));
            tick(1);
            check("reset_hold", {bus.data, bus.strobe, bus.active, bus.frame_err, bus.word_count}, 0);
        end
        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        tick(1);
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("reset_release", {bus.data, bus.strobe, bus.active, bus.frame_err, bus.word_count}, 0);
        end

        // table-driven windows
        for (int t = 0; t < 5; t++) begin
            wbuf[0] = tbl[t].w0;
            wbuf[1] = tbl[t].w1;
            wbuf[2] = tbl[t].w2;
            pword   = tbl[t].pw;
            run_window(tbl[t].nfull, tbl[t].pbits);
            check_window(tbl[t].exp_data, tbl[t].exp_strobes, tbl[t].exp_ferr,
                         tbl[t].exp_wc, tbl[t].nfull);
            model_data = tbl[t].exp_data;
        end

        // reselect 5 cycles into HOLD: active never drops, count restarts
        clear_mon();
        bus.cs_n = 1'b0;
        tick(4);
        send_word(32'hCAFEF00D, 32);
        tick(4);
        bus.cs_n = 1'b1;
        tick(5);
        bus.cs_n = 1'b0;
        tick(S + 3);
        check("reselect_wc_cleared", bus.word_count, 0);
        check("reselect_active", bus.active, 1);
        tick(1);
        send_word(32'h55AA33CC, 32);
        tick(4);
        bus.cs_n = 1'b1;
        c1 = cyc;
        wait_idle();
        tick(S + 4);
        check("reselect_strobes", sq_data.size(), 2);
        if (sq_data.size() == 2) begin
            check("reselect_wc0", sq_wc[0], 1);
            check("reselect_wc1", sq_wc[1], 1);
            check("reselect_data1", sq_data[1], 32'h55AA33CC);
        end
        check("reselect_falls", falls - fall0, 1);
        check("reselect_fall_latency", act_fall_cyc - c1, S + H + 1);
        check("reselect_ferr", ferr_cnt, 0);
        model_data = 32'h55AA33CC;

        // sclk pulses with cs_n high must not shift anything
        clear_mon();
        for (int i = 0; i < 32; i++) send_bit(1'($urandom_range(0, 1)));
        tick(S + 4);
        check("deselected_strobes", sq_data.size(), 0);
        check("deselected_ferr", ferr_cnt, 0);
        check("deselected_active", rises - rise0, 0);
        check("deselected_data", bus.data, model_data);

        // reset mid-word
        bus.cs_n = 1'b0;
        tick(4);
        send_word(32'hDEADBEEF, 20);
        tick(1);
        resetn = 1'b0;
        #1;
        check("midreset_data", bus.data, 0);
        check("midreset_strobe", bus.strobe, 0);
        check("midreset_active", bus.active, 0);
        check("midreset_ferr", bus.frame_err, 0);
        check("midreset_wc", bus.word_count, 0);
        bus.cs_n = 1'b1;
        tick(3);
        resetn = 1'b1;
        tick(4);
        model_data = 32'h0;
        wbuf[0] = 32'h12345678;
        run_window(1, 0);
        check_window(32'h12345678, 1, 0, 1, 1);
        model_data = 32'h12345678;

        // randomized windows against the transaction-level model
        for (int r = 0; r < 6; r++) begin
            int          nf, pb;
            logic [31:0] exp_d;
            nf = $urandom_range(0, 3);
            pb = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 31) : 0;
            if (nf == 0 && pb == 0) nf = 1;
            for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
            pword = $urandom;
            run_window(nf, pb);
            exp_d = (nf > 0) ? wbuf[nf - 1] : model_data;
            check_window(exp_d, nf, (pb != 0) ? 1 : 0, nf, nf);
            model_data = exp_d;
        end

        check("pulse_width", wide_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
